// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipeline controller: opcodes, funct codes,
// PC-source and ALU-op encodings, and the per-stage control words.
package ctrl_pkg;

    // Primary opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes with special control meaning
    localparam logic [5:0] FN_NOP  = 6'h00;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;

    // Register written by jal
    localparam int LINK_REG = 31;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10,
        PC_REG    = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_IMM   = 2'b11
    } alu_op_e;

    // Full control word as produced by decode and held in ID/EX
    typedef struct packed {
        logic    reg_write;
        logic    mem_to_reg;
        logic    mem_read;
        logic    mem_write;
        logic    link;
        logic    alu_src;
        alu_op_e alu_op;
    } ctrl_t;

    // Subset still needed after EX
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
        logic link;
    } mem_ctrl_t;

    // Subset still needed after MEM
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic link;
    } wb_ctrl_t;

    localparam ctrl_t     CTRL_BUBBLE     = '0;
    localparam mem_ctrl_t MEM_CTRL_BUBBLE = '0;
    localparam wb_ctrl_t  WB_CTRL_BUBBLE  = '0;

    // R-type funct codes that are plain ALU operations writing rd
    function automatic logic is_funct_alu(input logic [5:0] funct);
        case (funct)
            6'h20, 6'h21, 6'h22, 6'h23,
            6'h24, 6'h25, 6'h26, 6'h27,
            6'h2A, 6'h2B: is_funct_alu = 1'b1;
            default:      is_funct_alu = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: control word, destination register,
// PC source, source-register usage and illegal-instruction detection.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int RA_W     = 5,
    parameter int HAS_JALR = 1
) (
    input  logic            id_valid_i,
    input  logic [5:0]      id_op_i,
    input  logic [5:0]      id_funct_i,
    input  logic [RA_W-1:0] id_rt_i,
    input  logic [RA_W-1:0] id_rd_i,
    input  logic            id_eq_i,
    output ctrl_t           ctrl_o,
    output logic [RA_W-1:0] wdst_o,
    output pc_src_e         pc_src_o,
    output logic            uses_rs_o,
    output logic            uses_rt_o,
    output logic            br_src_o,
    output logic            illegal_o
);

    // Decode one instruction; anything not recognised becomes a bubble.
    always_comb begin
        // NOTE: every output gets a default before the case, so no path can leave one unassigned and infer a latch.
        ctrl_o    = CTRL_BUBBLE;
        wdst_o    = '0;
        pc_src_o  = PC_SEQ;
        uses_rs_o = 1'b0;
        uses_rt_o = 1'b0;
        br_src_o  = 1'b0;
        illegal_o = 1'b0;

        if (id_valid_i) begin
            case (id_op_i)
                OP_RTYPE: begin
                    if (id_funct_i == FN_NOP) begin
                        // all-zero control
                    end else if (id_funct_i == FN_JR) begin
                        pc_src_o  = PC_REG;
                        uses_rs_o = 1'b1;
                        br_src_o  = 1'b1;
                    end else if (id_funct_i == FN_JALR && HAS_JALR != 0) begin
                        pc_src_o         = PC_REG;
                        uses_rs_o        = 1'b1;
                        br_src_o         = 1'b1;
                        ctrl_o.reg_write = 1'b1;
                        ctrl_o.link      = 1'b1;
                        wdst_o           = id_rd_i;
                    end else if (is_funct_alu(id_funct_i)) begin
                        ctrl_o.reg_write = 1'b1;
                        ctrl_o.alu_op    = ALU_FUNCT;
                        wdst_o           = id_rd_i;
                        uses_rs_o        = 1'b1;
                        uses_rt_o        = 1'b1;
                    end else begin
                        illegal_o = 1'b1;
                    end
                end
                OP_LW: begin
                    ctrl_o.reg_write  = 1'b1;
                    ctrl_o.mem_to_reg = 1'b1;
                    ctrl_o.mem_read   = 1'b1;
                    ctrl_o.alu_src    = 1'b1;
                    wdst_o            = id_rt_i;
                    uses_rs_o         = 1'b1;
                end
                OP_SW: begin
                    ctrl_o.mem_write = 1'b1;
                    ctrl_o.alu_src   = 1'b1;
                    uses_rs_o        = 1'b1;
                    uses_rt_o        = 1'b1;
                end
                OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.alu_src   = 1'b1;
                    ctrl_o.alu_op    = ALU_IMM;
                    wdst_o           = id_rt_i;
                    uses_rs_o        = 1'b1;
                end
                OP_BEQ: begin
                    ctrl_o.alu_op = ALU_SUB;
                    uses_rs_o     = 1'b1;
                    uses_rt_o     = 1'b1;
                    br_src_o      = 1'b1;
                    pc_src_o      = id_eq_i ? PC_BRANCH : PC_SEQ;
                end
                OP_J: begin
                    pc_src_o = PC_JUMP;
                end
                OP_JAL: begin
                    pc_src_o         = PC_JUMP;
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.link      = 1'b1;
                    wdst_o           = RA_W'(LINK_REG);
                end
                default: begin
                    illegal_o = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipeline controller: hazard detection, ID/EX, EX/MEM and MEM/WB control
// registers, PC/IF-ID steering and a saturating hazard-stall counter.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int RA_W     = 5,
    parameter int CNT_W    = 16,
    parameter int HAS_JALR = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [5:0]       id_op,
    input  logic [5:0]       id_funct,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_eq,
    input  logic             mem_stall,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             if_flush,
    output logic [1:0]       pc_src,
    output logic [1:0]       ex_alu_op,
    output logic             ex_alu_src,
    output logic             ex_mem_read,
    output logic [RA_W-1:0]  ex_wdst,
    output logic             mem_mem_read,
    output logic             mem_mem_write,
    output logic             wb_reg_write,
    output logic             wb_mem_to_reg,
    output logic             wb_link,
    output logic [RA_W-1:0]  wb_wdst,
    output logic             illegal,
    output logic [CNT_W-1:0] stall_count
);

    ctrl_t           dec_ctrl;
    logic [RA_W-1:0] dec_wdst;
    pc_src_e         dec_pc_src;
    logic            dec_uses_rs;
    logic            dec_uses_rt;
    logic            dec_br_src;
    logic            dec_illegal;

    ctrl_t           ex_ctrl_q,  ex_ctrl_d;
    logic [RA_W-1:0] ex_wdst_q,  ex_wdst_d;
    mem_ctrl_t       mem_ctrl_q, mem_ctrl_d;
    logic [RA_W-1:0] mem_wdst_q;
    wb_ctrl_t        wb_ctrl_q,  wb_ctrl_d;
    logic [RA_W-1:0] wb_wdst_q;
    logic            illegal_q,  illegal_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic ex_dep;
    logic mem_dep;
    logic load_use;
    logic branch_haz;
    logic hazard;

    ctrl_decode #(
        .RA_W     (RA_W),
        .HAS_JALR (HAS_JALR)
    ) u_decode (
        .id_valid_i (id_valid),
        .id_op_i    (id_op),
        .id_funct_i (id_funct),
        .id_rt_i    (id_rt),
        .id_rd_i    (id_rd),
        .id_eq_i    (id_eq),
        .ctrl_o     (dec_ctrl),
        .wdst_o     (dec_wdst),
        .pc_src_o   (dec_pc_src),
        .uses_rs_o  (dec_uses_rs),
        .uses_rt_o  (dec_uses_rt),
        .br_src_o   (dec_br_src),
        .illegal_o  (dec_illegal)
    );

    // Hazard detection: load-use against EX, and branch/jump-register operands against EX writers and MEM loads.
    always_comb begin
        ex_dep     = (ex_wdst_q != '0) &&
                     ((dec_uses_rs && ex_wdst_q == id_rs) || (dec_uses_rt && ex_wdst_q == id_rt));
        mem_dep    = (dec_uses_rs && mem_wdst_q == id_rs) || (dec_uses_rt && mem_wdst_q == id_rt);
        load_use   = ex_ctrl_q.mem_read && ex_dep;
        branch_haz = dec_br_src && ((ex_ctrl_q.reg_write && ex_dep) || (mem_ctrl_q.mem_read && mem_dep));
        hazard     = load_use || branch_haz;
    end

    // Fetch steering: reset forces sequential fetch, freeze and hazard hold fetch, otherwise follow decode.
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        if_flush   = 1'b0;
        pc_src     = PC_SEQ;
        if (rst) begin
            // keep the defaults while reset is asserted
        end else if (mem_stall || hazard) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else begin
            pc_src   = dec_pc_src;
            if_flush = (dec_pc_src != PC_SEQ);
        end
    end

    // Next-state values for the pipeline registers and the stall counter.
    always_comb begin
        ex_ctrl_d     = hazard ? CTRL_BUBBLE : dec_ctrl;
        ex_wdst_d     = hazard ? '0 : dec_wdst;
        mem_ctrl_d    = '{reg_write:  ex_ctrl_q.reg_write,
                          mem_to_reg: ex_ctrl_q.mem_to_reg,
                          mem_read:   ex_ctrl_q.mem_read,
                          mem_write:  ex_ctrl_q.mem_write,
                          link:       ex_ctrl_q.link};
        wb_ctrl_d     = '{reg_write:  mem_ctrl_q.reg_write,
                          mem_to_reg: mem_ctrl_q.mem_to_reg,
                          link:       mem_ctrl_q.link};
        illegal_d     = dec_illegal && !mem_stall;
        stall_count_d = stall_count_q;
        if (hazard && stall_count_q != {CNT_W{1'b1}}) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    // Pipeline registers and counter; mem_stall freezes them, the illegal pulse is never held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_ctrl_q     <= CTRL_BUBBLE;
            ex_wdst_q     <= '0;
            mem_ctrl_q    <= MEM_CTRL_BUBBLE;
            mem_wdst_q    <= '0;
            wb_ctrl_q     <= WB_CTRL_BUBBLE;
            wb_wdst_q     <= '0;
            illegal_q     <= 1'b0;
            stall_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every stage samples the previous stage's old value on the same edge.
            illegal_q <= illegal_d;
            if (!mem_stall) begin
                ex_ctrl_q     <= ex_ctrl_d;
                ex_wdst_q     <= ex_wdst_d;
                mem_ctrl_q    <= mem_ctrl_d;
                mem_wdst_q    <= ex_wdst_q;
                wb_ctrl_q     <= wb_ctrl_d;
                wb_wdst_q     <= mem_wdst_q;
                stall_count_q <= stall_count_d;
            end
        end
    end

    assign ex_alu_op     = ex_ctrl_q.alu_op;
    assign ex_alu_src    = ex_ctrl_q.alu_src;
    assign ex_mem_read   = ex_ctrl_q.mem_read;
    assign ex_wdst       = ex_wdst_q;
    assign mem_mem_read  = mem_ctrl_q.mem_read;
    assign mem_mem_write = mem_ctrl_q.mem_write;
    assign wb_reg_write  = wb_ctrl_q.reg_write && (wb_wdst_q != '0);
    assign wb_mem_to_reg = wb_ctrl_q.mem_to_reg;
    assign wb_link       = wb_ctrl_q.link;
    assign wb_wdst       = wb_wdst_q;
    assign illegal       = illegal_q;
    assign stall_count   = stall_count_q;

endmodule
